// File: rtl/seq_pkg.sv
// Shared frame-state type and default word width for the sequence serializer.
package seq_pkg;
  localparam int SEQ_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
endpackage

// File: rtl/seq_bit_counter.sv
// Frame-bit counter: clear has priority over enable; last flags the final data bit.
// One-cycle update latency, no backpressure.
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == LAST_IDX);
endmodule

// File: rtl/seq_serializer.sv
// Word-to-bit serializer (MSB first, LSB_FIRST=1 reverses); first bit one cycle after transfer.
// din_ready only in IDLE, PAR and the last data bit; SEQ_SERIALIZER_PARITY_EN appends even parity.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int W         = SEQ_W,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         out,
  output logic         out_valid,
  output logic         busy
);
  state_t       state;
  logic [W-1:0] sreg;
  logic         last;
  logic         xfer;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic         par;
`endif

  function automatic logic head(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[W-1];
  endfunction

  function automatic logic [W-1:0] tail(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Ready depends only on state and counter, so no valid->ready path exists.
  always_comb begin
    din_ready = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      SHIFT:   din_ready = 1'b0;
      PAR:     din_ready = 1'b1;
`else
      SHIFT:   din_ready = last;
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign xfer = din_valid & din_ready;
  assign busy = (state != IDLE);

  seq_bit_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer),
    .en    (state == SHIFT),
    .last  (last)
  );

  // out holds the bit on the wire; sreg holds the bits still to come.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (xfer) begin
      state     <= SHIFT;
      sreg      <= tail(din);
      out       <= head(din);
      out_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par       <= ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (!last) begin
            sreg <= tail(sreg);
            out  <= head(sreg);
          end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
            state <= PAR;
            out   <= par;
`else
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: queue-based frame model checked every cycle, plus literal frame checks.
module tb_seq_serializer;
  import seq_pkg::*;

  localparam int W = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy_m, out_m, vld_m, busy_m;
  logic         rdy_l, out_l, vld_l, busy_l;

  always #5 clk = ~clk;

  seq_serializer #(.W(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .out(out_m), .out_valid(vld_m), .busy(busy_m)
  );

  seq_serializer #(.W(W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .out(out_l), .out_valid(vld_l), .busy(busy_l)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Bit i of a frame: data bits in shift order, then the parity bit.
  function automatic bit fbit(input logic [W-1:0] w, input bit lsb, input int i);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  // Model: a queue of bits still owed after the one currently on the wire.
  bit q_m[$];
  bit q_l[$];
  bit cur_m, cur_l, cur_v;
  int acc_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m.delete();
      q_l.delete();
      cur_m <= 1'b0;
      cur_l <= 1'b0;
      cur_v <= 1'b0;
    end else begin
      if (din_valid && q_m.size() == 0) begin
        for (int i = 0; i < FL; i++) begin
          q_m.push_back(fbit(din, 1'b0, i));
          q_l.push_back(fbit(din, 1'b1, i));
        end
        acc_cnt <= acc_cnt + 1;
      end
      if (q_m.size() > 0) begin
        cur_m <= q_m.pop_front();
        cur_l <= q_l.pop_front();
        cur_v <= 1'b1;
      end else begin
        cur_m <= 1'b0;
        cur_l <= 1'b0;
        cur_v <= 1'b0;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_msb", 32'(out_m), 32'(cur_m));
      chk("out_lsb", 32'(out_l), 32'(cur_l));
      chk("out_valid", 32'(vld_m), 32'(cur_v));
      chk("out_valid_lsb", 32'(vld_l), 32'(cur_v));
      chk("din_ready", 32'(rdy_m), 32'(q_m.size() == 0));
      chk("din_ready_lsb", 32'(rdy_l), 32'(q_m.size() == 0));
      chk("busy", 32'(busy_m), 32'(cur_v));
    end
  end

  // Captured streams and a behavioural 101 detector on the MSB-first stream.
  logic [31:0] cap_m = '0, cap_l = '0;
  int          ncap = 0;
  logic [2:0]  hist = '0;
  int          det_cnt = 0;
  always @(negedge clk) begin
    if (vld_m === 1'b1) begin
      cap_m <= {cap_m[30:0], out_m};
      cap_l <= {cap_l[30:0], out_l};
      ncap  <= ncap + 1;
      hist  <= {hist[1:0], out_m};
      if ({hist[1:0], out_m} == 3'b101) det_cnt <= det_cnt + 1;
    end
  end

  task automatic send(input logic [W-1:0] w);
    int a0;
    a0 = acc_cnt;
    din = w;
    din_valid = 1'b1;
    for (int k = 0; k < 40 && acc_cnt == a0; k++) @(negedge clk);
    if (acc_cnt == a0) chk("accept_timeout", 32'(acc_cnt), 32'(a0 + 1));
    #1;
  endtask

  task automatic wait_bits(input int n0, input int n);
    for (int k = 0; k < 100 && ncap < n0 + n; k++) @(negedge clk);
    if (ncap < n0 + n) chk("bits_timeout", 32'(ncap), 32'(n0 + n));
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n0, d0;
    logic [W-1:0] v;

    // Pin the frame model against hand-computed frames.
    v = '0;
    for (int i = 0; i < W; i++) v = {v[W-2:0], fbit(8'hA5, 1'b0, i)};
    chk("model_a5_msb", 32'(v), 32'h0000_00A5);
    v = '0;
    for (int i = 0; i < W; i++) v = {v[W-2:0], fbit(8'h01, 1'b1, i)};
    chk("model_01_lsb", 32'(v), 32'h0000_0080);
    chk("model_par_a5", 32'(fbit(8'hA5, 1'b0, W)), 32'h0);
    chk("model_par_07", 32'(fbit(8'h07, 1'b0, W)), 32'h1);

    #1 rst_n = 1'b0;
    #11;
    chk("rst_out", 32'(out_m), 32'h0);
    chk("rst_out_valid", 32'(vld_m), 32'h0);
    chk("rst_busy", 32'(busy_m), 32'h0);
    chk("rst_din_ready", 32'(rdy_m), 32'h1);
    cmp_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 0xA5 accepted on the first edge after release, then 0x0F back-to-back.
    n0 = ncap;
    send(8'hA5);
    send(8'h0F);
    din_valid = 1'b0;
    wait_bits(n0, 2 * FL);
`ifdef SEQ_SERIALIZER_PARITY_EN
    chk("frame_a5_0f", cap_m & 32'h3FFFF, 32'b10100101_0_00001111_0);
`else
    chk("frame_a5_0f", cap_m & 32'hFFFF, 32'h0000_A50F);
`endif
    repeat (3) @(negedge clk);

    // 0x01 on both bit orders.
    n0 = ncap;
    send(8'h01);
    din_valid = 1'b0;
    wait_bits(n0, FL);
    chk("frame_01_msb", (cap_m >> (FL - W)) & 32'hFF, 32'h01);
    chk("frame_01_lsb", (cap_l >> (FL - W)) & 32'hFF, 32'h80);
    repeat (2) @(negedge clk);

`ifdef SEQ_SERIALIZER_PARITY_EN
    n0 = ncap;
    send(8'h07);
    din_valid = 1'b0;
    wait_bits(n0, FL);
    chk("parity_07", cap_m & 32'h1FF, 32'b00000111_1);
    repeat (2) @(negedge clk);
`endif

    // Reset during bit 4 of a 0xFF frame.
    n0 = ncap;
    send(8'hFF);
    din_valid = 1'b0;
    wait_bits(n0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out_m), 32'h0);
    chk("midrst_out_valid", 32'(vld_m), 32'h0);
    chk("midrst_busy", 32'(busy_m), 32'h0);
    chk("midrst_din_ready", 32'(rdy_m), 32'h1);
    chk("midrst_bits_seen", 32'((cap_m & 32'hF) == 32'hF), 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n0 = ncap;
    repeat (12) @(negedge clk);
    chk("midrst_no_more_bits", 32'(ncap), 32'(n0));

    // 0x05 into the 101 detector: one hit, on the final data bit.
    n0 = ncap;
    d0 = det_cnt;
    send(8'h05);
    din_valid = 1'b0;
    wait_bits(n0, W - 1);
    chk("det_before_last", 32'(det_cnt - d0), 32'h0);
    wait_bits(n0, W);
    chk("det_on_last", 32'(det_cnt - d0), 32'h1);
    chk("det_hist", 32'(hist), 32'b101);
    chk("frame_05", cap_m & 32'hFF, 32'h05);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
